// File: rtl/e2m0_pkg.sv
// Shared types and constants for the E2M0 x int8 dual-lane dot-product tile.
package e2m0_pkg;

    localparam int LANES     = 2;
    localparam int CODE_W    = 3;
    localparam int ACC_W     = 18;
    localparam int OUT_B     = 3;
    localparam int PROD_W    = 11;
    localparam int LANE_SR_W = OUT_B * 8;
    localparam int SR_W      = LANES * LANE_SR_W;

    typedef enum logic [1:0] {
        CMD_IDLE = 2'b00,
        CMD_ACC  = 2'b01,
        CMD_LOAD = 2'b10,
        CMD_SNAP = 2'b11
    } cmd_t;

    // Maps a {sign, exp[1:0]} weight code to its value in {0, +-1, +-2, +-4}.
    function automatic logic signed [3:0] e2m0_decode(input logic [CODE_W-1:0] code);
        logic signed [3:0] mag;
        case (code[1:0])
            2'd0:    mag = 4'sd0;
            2'd1:    mag = 4'sd1;
            2'd2:    mag = 4'sd2;
            default: mag = 4'sd4;
        endcase
        return code[2] ? -mag : mag;
    endfunction

endpackage

// File: rtl/e2m0_mul.sv
// Combinational int8 x E2M0 multiplier: shift by the exponent, then negate on sign.
module e2m0_mul
    import e2m0_pkg::*;
(
    input  logic signed [7:0]        a,
    input  logic        [CODE_W-1:0] code,
    output logic signed [PROD_W-1:0] p
);

    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] mag;

    // Exponent 0 encodes zero, so the negative-zero code also yields zero.
    always_comb begin
        a_ext = {{(PROD_W-8){a[7]}}, a};
        case (code[1:0])
            2'd0:    mag = '0;
            2'd1:    mag = a_ext;
            2'd2:    mag = a_ext <<< 1;
            default: mag = a_ext <<< 2;
        endcase
        p = code[2] ? -mag : mag;
    end

endmodule

// File: rtl/e2m0_x_i8_matmul.sv
// Dual-lane dot-product tile: per-lane accumulators plus a bytewise readout shift register.
module e2m0_x_i8_matmul
    import e2m0_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    cmd_t                     cmd;
    logic        [CODE_W-1:0] w_code [LANES];
    logic signed [PROD_W-1:0] prod   [LANES];
    logic signed [ACC_W-1:0]  acc_q  [LANES];
    logic signed [ACC_W-1:0]  acc_d  [LANES];
    logic        [SR_W-1:0]   sr_q;
    logic        [SR_W-1:0]   sr_d;

    assign cmd       = cmd_t'(ui_in[7:6]);
    assign w_code[0] = ui_in[2:0];
    assign w_code[1] = ui_in[5:3];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        e2m0_mul u_mul (
            .a    (uio_in),
            .code (w_code[l]),
            .p    (prod[l])
        );
    end

    // Next-state for accumulators and readout register; ena low freezes everything.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            acc_d[l] = acc_q[l];
        end
        sr_d = sr_q;
        if (ena) begin
            case (cmd)
                CMD_IDLE: ;
                CMD_ACC: begin
                    for (int l = 0; l < LANES; l++) begin
                        acc_d[l] = acc_q[l] + {{(ACC_W-PROD_W){prod[l][PROD_W-1]}}, prod[l]};
                    end
                end
                CMD_LOAD: begin
                    for (int l = 0; l < LANES; l++) begin
                        acc_d[l] = {{(ACC_W-PROD_W){prod[l][PROD_W-1]}}, prod[l]};
                    end
                end
                CMD_SNAP: begin
                    for (int l = 0; l < LANES; l++) begin
                        sr_d[l*LANE_SR_W +: LANE_SR_W] =
                            {{(LANE_SR_W-ACC_W){acc_q[l][ACC_W-1]}}, acc_q[l]};
                    end
                end
            endcase
            if (cmd != CMD_SNAP) begin
                sr_d = sr_q >> 8;
            end
        end
    end

    // State registers; the active-high synchronous reset wins over ena and cmd.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int l = 0; l < LANES; l++) begin
                acc_q[l] <= '0;
            end
            sr_q <= '0;
        end else begin
            for (int l = 0; l < LANES; l++) begin
                acc_q[l] <= acc_d[l];
            end
            sr_q <= sr_d;
        end
    end

    assign uo_out  = sr_q[7:0];
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_e2m0_x_i8_matmul.sv
// Self-checking bench for e2m0_x_i8_matmul with directed scenarios and a random run
// checked against a queue-based behavioural model.
module tb_e2m0_x_i8_matmul;

    localparam logic [1:0] C_IDLE = 2'b00;
    localparam logic [1:0] C_ACC  = 2'b01;
    localparam logic [1:0] C_LOAD = 2'b10;
    localparam logic [1:0] C_SNAP = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_cmp  = 0;
    int n_fail = 0;

    int         m_acc [2];
    logic [7:0] m_q [$];
    int         wval [8] = '{0, 1, 2, 4, 0, -1, -2, -4};

    e2m0_x_i8_matmul dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    function automatic int wrap18(input int v);
        int m;
        m = v & 32'h3FFFF;
        if (m[17]) m = m - 262144;
        return m;
    endfunction

    function automatic logic [7:0] exp_byte();
        return (m_q.size() > 0) ? m_q[0] : 8'h00;
    endfunction

    // Drive one clock cycle and advance the reference model; returns 1ns after the edge.
    task automatic step(input logic [1:0] cmd, input logic [7:0] a, input logic [2:0] w0,
                        input logic [2:0] w1, input logic en, input logic rst);
        int p0, p1, old0, old1;
        rst_n  = rst;
        ena    = en;
        ui_in  = {cmd, w1, w0};
        uio_in = a;
        @(posedge clk);
        p0 = int'($signed(a)) * wval[w0];
        p1 = int'($signed(a)) * wval[w1];
        if (rst) begin
            m_acc[0] = 0;
            m_acc[1] = 0;
            m_q.delete();
        end else if (en) begin
            old0 = m_acc[0];
            old1 = m_acc[1];
            case (cmd)
                C_ACC: begin
                    m_acc[0] = wrap18(old0 + p0);
                    m_acc[1] = wrap18(old1 + p1);
                end
                C_LOAD: begin
                    m_acc[0] = wrap18(p0);
                    m_acc[1] = wrap18(p1);
                end
                C_SNAP: begin
                    m_q.delete();
                    for (int k = 0; k < 3; k++) m_q.push_back(8'((old0 >>> (8*k)) & 255));
                    for (int k = 0; k < 3; k++) m_q.push_back(8'((old1 >>> (8*k)) & 255));
                end
                default: ;
            endcase
            if (cmd != C_SNAP && m_q.size() > 0) void'(m_q.pop_front());
        end
        #1;
    endtask

    task automatic test_reset();
        step(C_ACC, 8'h7F, 3'b011, 3'b011, 1'b1, 1'b1);
        step(C_ACC, 8'h7F, 3'b011, 3'b011, 1'b1, 1'b1);
        n_cmp++;
        if (uo_out !== 8'h00) begin
            n_fail++; $display("[TB] FAIL reset_uo_out: got %02h expected 00", uo_out);
        end
        n_cmp++;
        if (uio_oe !== 8'h00 || uio_out !== 8'h00) begin
            n_fail++; $display("[TB] FAIL reset_uio: got oe=%02h out=%02h expected 00", uio_oe, uio_out);
        end
        step(C_SNAP, 8'h00, 3'b000, 3'b000, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            n_cmp++;
            if (uo_out !== 8'h00) begin
                n_fail++; $display("[TB] FAIL reset_stream[%0d]: got %02h expected 00", i, uo_out);
            end
            step(C_IDLE, 8'h00, 3'b000, 3'b000, 1'b1, 1'b0);
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp [7] = '{8'h06, 8'hFE, 8'hFF, 8'h74, 8'hFF, 8'hFF, 8'h00};
        step(C_LOAD, 8'd3,   3'b010, 3'b111, 1'b1, 1'b0);
        step(C_ACC,  8'h80,  3'b011, 3'b001, 1'b1, 1'b0);
        step(C_SNAP, 8'h00,  3'b000, 3'b000, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            n_cmp++;
            if (uo_out !== exp[i]) begin
                n_fail++; $display("[TB] FAIL basic[%0d]: got %02h expected %02h", i, uo_out, exp[i]);
            end
            step(C_IDLE, 8'h00, 3'b000, 3'b000, 1'b1, 1'b0);
        end
    endtask

    task automatic test_zero_codes();
        step(C_LOAD, 8'd100, 3'b000, 3'b100, 1'b1, 1'b0);
        step(C_SNAP, 8'h00,  3'b000, 3'b000, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            n_cmp++;
            if (uo_out !== 8'h00) begin
                n_fail++; $display("[TB] FAIL zero_codes[%0d]: got %02h expected 00", i, uo_out);
            end
            step(C_IDLE, 8'h00, 3'b000, 3'b000, 1'b1, 1'b0);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp [7] = '{8'h00, 8'h00, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00};
        step(C_LOAD, 8'h80, 3'b111, 3'b000, 1'b1, 1'b0);
        for (int i = 0; i < 255; i++) step(C_ACC, 8'h80, 3'b111, 3'b000, 1'b1, 1'b0);
        step(C_SNAP, 8'h00, 3'b000, 3'b000, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            n_cmp++;
            if (uo_out !== exp[i]) begin
                n_fail++; $display("[TB] FAIL wrap[%0d]: got %02h expected %02h", i, uo_out, exp[i]);
            end
            step(C_IDLE, 8'h00, 3'b000, 3'b000, 1'b1, 1'b0);
        end
    endtask

    task automatic test_hold();
        logic [7:0] exp [6] = '{8'hFF, 8'h38, 8'hFF, 8'hFF, 8'h00, 8'h00};
        // acc0 = -100*4 = -400 (FFFE70), acc1 = -100*2 = -200 (FFFF38)
        step(C_LOAD, 8'h9C, 3'b011, 3'b010, 1'b1, 1'b0);
        step(C_SNAP, 8'h00, 3'b000, 3'b000, 1'b1, 1'b0);
        n_cmp++;
        if (uo_out !== 8'h70) begin
            n_fail++; $display("[TB] FAIL hold_b0: got %02h expected 70", uo_out);
        end
        step(C_IDLE, 8'h00, 3'b000, 3'b000, 1'b1, 1'b0);
        step(C_ACC,  8'h55, 3'b011, 3'b011, 1'b0, 1'b0);
        step(C_SNAP, 8'h12, 3'b001, 3'b001, 1'b0, 1'b0);
        step(C_LOAD, 8'h7F, 3'b010, 3'b110, 1'b0, 1'b0);
        n_cmp++;
        if (uo_out !== 8'hFE) begin
            n_fail++; $display("[TB] FAIL hold_frozen: got %02h expected FE", uo_out);
        end
        for (int i = 0; i < 6; i++) begin
            step(C_IDLE, 8'h00, 3'b000, 3'b000, 1'b1, 1'b0);
            n_cmp++;
            if (uo_out !== exp[i]) begin
                n_fail++; $display("[TB] FAIL hold_resume[%0d]: got %02h expected %02h", i, uo_out, exp[i]);
            end
        end
        step(C_SNAP, 8'h00, 3'b000, 3'b000, 1'b1, 1'b0);
        n_cmp++;
        if (uo_out !== 8'h70) begin
            n_fail++; $display("[TB] FAIL hold_acc_kept: got %02h expected 70", uo_out);
        end
    endtask

    task automatic test_overlap();
        logic [7:0] exp [7] = '{8'h0F, 8'h00, 8'h00, 8'hF3, 8'hFF, 8'hFF, 8'h00};
        step(C_LOAD, 8'd5, 3'b001, 3'b001, 1'b1, 1'b0);
        step(C_SNAP, 8'd0, 3'b000, 3'b000, 1'b1, 1'b0);
        n_cmp++;
        if (uo_out !== 8'h05) begin
            n_fail++; $display("[TB] FAIL overlap_first: got %02h expected 05", uo_out);
        end
        step(C_LOAD, 8'd7, 3'b010, 3'b110, 1'b1, 1'b0);
        step(C_ACC,  8'd1, 3'b001, 3'b001, 1'b1, 1'b0);
        step(C_SNAP, 8'd0, 3'b000, 3'b000, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            n_cmp++;
            if (uo_out !== exp[i]) begin
                n_fail++; $display("[TB] FAIL overlap[%0d]: got %02h expected %02h", i, uo_out, exp[i]);
            end
            step(C_IDLE, 8'h00, 3'b000, 3'b000, 1'b1, 1'b0);
        end
    endtask

    task automatic test_reset_mid_readout();
        step(C_LOAD, 8'hFF, 3'b001, 3'b001, 1'b1, 1'b0);
        step(C_SNAP, 8'h00, 3'b000, 3'b000, 1'b1, 1'b0);
        step(C_IDLE, 8'h00, 3'b000, 3'b000, 1'b1, 1'b0);
        n_cmp++;
        if (uo_out !== 8'hFF) begin
            n_fail++; $display("[TB] FAIL midreset_pre: got %02h expected FF", uo_out);
        end
        step(C_SNAP, 8'h00, 3'b000, 3'b000, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (uo_out !== 8'h00) begin
                n_fail++; $display("[TB] FAIL midreset[%0d]: got %02h expected 00", i, uo_out);
            end
            step(C_IDLE, 8'h00, 3'b000, 3'b000, 1'b1, 1'b0);
        end
        step(C_SNAP, 8'h00, 3'b000, 3'b000, 1'b1, 1'b0);
        n_cmp++;
        if (uo_out !== 8'h00) begin
            n_fail++; $display("[TB] FAIL midreset_acc_cleared: got %02h expected 00", uo_out);
        end
    endtask

    task automatic test_random();
        logic [1:0] cmd;
        logic       en, rst;
        logic [7:0] eb;
        for (int i = 0; i < 600; i++) begin
            cmd = 2'($urandom_range(0, 3));
            en  = ($urandom_range(0, 7) != 0);
            rst = ($urandom_range(0, 149) == 0);
            step(cmd, 8'($urandom), 3'($urandom), 3'($urandom), en, rst);
            eb = exp_byte();
            n_cmp++;
            if (uo_out !== eb) begin
                n_fail++; $display("[TB] FAIL random[%0d]: got %02h expected %02h", i, uo_out, eb);
            end
            if (i % 100 == 0) begin
                n_cmp++;
                if (uio_oe !== 8'h00 || uio_out !== 8'h00) begin
                    n_fail++; $display("[TB] FAIL random_uio[%0d]: got oe=%02h out=%02h expected 00", i, uio_oe, uio_out);
                end
            end
        end
    endtask

    initial begin
        rst_n  = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        m_acc[0] = 0;
        m_acc[1] = 0;
        #2;
        test_reset();
        test_basic();
        test_zero_codes();
        test_wrap();
        test_hold();
        test_overlap();
        test_reset_mid_readout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
